ffi: RTL and testbench



---
 rtl/ffi_pkg.sv | 18 +
 rtl/ffi_if.sv | 15 +
 rtl/ffi_mod_addsub.sv | 40 ++++
 rtl/ffi.sv | 131 +++++++++++++
 tb/tb_ffi.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/ffi_pkg.sv
// Shared constants and types for the field inverter over p = 2^255-19.
package ffi_pkg;

  localparam int FFI_W = 255;
  localparam logic [255:0] P_EXT =
    256'h7fffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffed;
  localparam logic [FFI_W-1:0] P = P_EXT[FFI_W-1:0];

  // Worst-case cycles from RUN entry to DONE for any a in [1, p-1].
  localparam int LAT_MAX = 1040;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } ffi_state_e;

endpackage

// File: rtl/ffi_if.sv
// Operand/result bundle of the inverter plus the FSM state for observation.
interface ffi_if;
  import ffi_pkg::*;

  // valid is a level, not a handshake: it is high exactly while res is the
  // inverse of the a currently on the bus; there is no ready, consumers sample.
  logic [FFI_W-1:0] a;
  logic [FFI_W-1:0] res;
  logic             valid;
  ffi_state_e       dbg_state;

  modport master (output a, input res, input valid, input dbg_state);
  modport slave  (input a, output res, output valid, output dbg_state);

endinterface

// File: rtl/ffi_mod_addsub.sv
// Combinational (x +/- y) mod p and modular halving of x, using 256-bit sums.
module ffi_mod_addsub
  import ffi_pkg::*;
(
  input  logic [FFI_W-1:0] x,
  input  logic [FFI_W-1:0] y,
  input  logic             sub,
  output logic [FFI_W-1:0] sum,
  output logic [FFI_W-1:0] half
);

  logic [FFI_W:0] p_ext;
  logic [FFI_W:0] x_ext;
  logic [FFI_W:0] y_ext;
  logic [FFI_W:0] s_raw;
  logic [FFI_W:0] d_raw;
  logic [FFI_W:0] h_raw;
  logic           unused_bits;

  always_comb begin
    p_ext = {1'b0, P};
    x_ext = {1'b0, x};
    y_ext = {1'b0, y};
    s_raw = x_ext + y_ext;
    if (s_raw >= p_ext) begin
      s_raw = s_raw - p_ext;
    end
    d_raw = x_ext - y_ext;
    if (x_ext < y_ext) begin
      d_raw = d_raw + p_ext;
    end
    sum = sub ? d_raw[FFI_W-1:0] : s_raw[FFI_W-1:0];
    // odd x: x+p is even and below 2^256, so the shift is an exact halving
    h_raw = x[0] ? (x_ext + p_ext) : x_ext;
    half  = h_raw[FFI_W:1];
  end

  assign unused_bits = ^{s_raw[FFI_W], d_raw[FFI_W], h_raw[0]};

endmodule

// File: rtl/ffi.sv
// Modular inverse a^-1 mod (2^255-19) by binary extended Euclid, one step per clock.
// Optional input reduction of a >= p is enabled with macro FFI_REDUCE_IN_EN.
module ffi #(
  parameter int W = 255
) (
  input logic  clk,
  input logic  rst,
  ffi_if.slave bus
);
  import ffi_pkg::*;

  ffi_state_e state;
  ffi_state_e state_nxt;

  logic [W-1:0] a_lat;
  logic [W-1:0] a_in;
  logic [W-1:0] u;
  logic [W-1:0] v;
  logic [W-1:0] x1;
  logic [W-1:0] x2;
  logic [W-1:0] res_q;
  logic [W-1:0] ms_x;
  logic [W-1:0] ms_y;
  logic [W-1:0] ms_sum;
  logic [W-1:0] ms_half;

  logic start;
  logic finish;
  logic u_zero;
  logic u_one;
  logic v_one;
  logic u_even;
  logic v_even;
  logic u_ge_v;
  logic sel_x1;

  // a_lat keeps the raw bus value so change detection and valid compare like for like
`ifdef FFI_REDUCE_IN_EN
  assign a_in = (bus.a >= P) ? (bus.a - P) : bus.a;
`else
  assign a_in = bus.a;
`endif

  assign start  = (state == IDLE) || (bus.a != a_lat);
  assign u_zero = (u == '0);
  assign u_one  = (u == W'(1));
  assign v_one  = (v == W'(1));
  assign finish = u_zero || u_one || v_one;
  assign u_even = ~u[0];
  assign v_even = ~v[0];
  assign u_ge_v = (u >= v);

  // x1 is the working coefficient when u is halved or u absorbs v
  assign sel_x1 = u_even || (!v_even && u_ge_v);
  assign ms_x   = sel_x1 ? x1 : x2;
  assign ms_y   = sel_x1 ? x2 : x1;

  ffi_mod_addsub u_addsub (
    .x    (ms_x),
    .y    (ms_y),
    .sub  (1'b1),
    .sum  (ms_sum),
    .half (ms_half)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = RUN;
      RUN: begin
        if (start) begin
          state_nxt = RUN;
        end else if (finish) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (start) begin
          state_nxt = RUN;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_lat <= '0;
      u     <= '0;
      v     <= '0;
      x1    <= '0;
      x2    <= '0;
      res_q <= '0;
    end else if (start) begin
      a_lat <= bus.a;
      u     <= a_in;
      v     <= P;
      x1    <= W'(1);
      x2    <= '0;
    end else if (state == RUN) begin
      if (finish) begin
        res_q <= u_zero ? '0 : (u_one ? x1 : x2);
      end else if (u_even) begin
        u  <= u >> 1;
        x1 <= ms_half;
      end else if (v_even) begin
        v  <= v >> 1;
        x2 <= ms_half;
      end else if (u_ge_v) begin
        u  <= u - v;
        x1 <= ms_sum;
      end else begin
        v  <= v - u;
        x2 <= ms_sum;
      end
    end
  end

  assign bus.res       = res_q;
  assign bus.valid     = (state == DONE) && (bus.a == a_lat);
  assign bus.dbg_state = state;

endmodule

// File: tb/tb_ffi.sv
// Bench for ffi: directed table, abort/reset sequences and random operands vs. a Fermat model.
module tb_ffi;
  import ffi_pkg::*;

  typedef logic [254:0] fe_t;
  typedef struct {
    fe_t a;
    fe_t exp_res;
    int  max_lat;
  } vec_t;

  localparam int N_RAND = 40;

  logic clk;
  logic rst;
  ffi_if bus ();

  ffi #(.W(255)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int  n_vec = 0;
  int  n_err = 0;
  fe_t exp_q[$];
  fe_t last_exp;

  // ---------------- reference model ----------------
  function automatic fe_t mulmod(input fe_t x, input fe_t y);
    logic [511:0] prod;
    logic [511:0] pm;
    logic [511:0] r;
    prod = {257'b0, x} * {257'b0, y};
    pm   = {257'b0, P};
    r    = prod % pm;
    return r[254:0];
  endfunction

  // Fermat: a^(p-2) mod p, which is 0 for a == 0
  function automatic fe_t modinv(input fe_t a);
    fe_t e;
    fe_t acc;
    fe_t base;
    e    = P - fe_t'(2);
    acc  = fe_t'(1);
    base = mulmod(a, fe_t'(1));
    for (int i = 0; i < 255; i++) begin
      if (e[i]) acc = mulmod(acc, base);
      base = mulmod(base, base);
    end
    return acc;
  endfunction

  function automatic fe_t rand_fe();
    logic [255:0] r256;
    fe_t r;
    do begin
      if ($urandom_range(0, 3) == 0) begin
        r = fe_t'($urandom_range(1, 100000));
      end else begin
        r256 = '0;
        for (int i = 0; i < 8; i++) r256 = {r256[223:0], $urandom};
        r = r256[254:0];
      end
    end while (r == '0 || r >= P || r == bus.a);
    return r;
  endfunction

  // ---------------- checks ----------------
  task automatic check_fe(input string name, input fe_t act, input fe_t exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic set_a(input fe_t val);
    @(negedge clk);
    bus.a = val;
    #1;
  endtask

  // lat counts rising edges since the change; the first one is RUN entry
  task automatic wait_valid(input int max_lat, output int lat);
    lat = 0;
    while (bus.valid !== 1'b1 && lat < max_lat + 4) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic finish_vec(input fe_t a, input int max_lat);
    int  lat;
    fe_t exp;
    wait_valid(max_lat, lat);
    n_vec++;
    if (bus.valid !== 1'b1 || lat - 1 > max_lat) begin
      n_err++;
      $display("FAIL latency a=%h: got %0d cycles (valid=%b) limit %0d", a, lat - 1, bus.valid, max_lat);
    end
    exp = exp_q.pop_front();
    last_exp = exp;
    check_fe("res", bus.res, exp);
    check_fe("a_times_res", mulmod(a, bus.res), (exp == '0) ? fe_t'(0) : fe_t'(1));
    repeat (3) @(negedge clk);
    check_fe("hold_res", bus.res, exp);
    check_bit("hold_valid", bus.valid, 1'b1);
  endtask

  task automatic run_vec(input fe_t a, input fe_t exp_res, input int max_lat);
    exp_q.push_back(exp_res);
    set_a(a);
    finish_vec(a, max_lat);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- test ----------------
  initial begin
    vec_t         tbl[6];
    logic [257:0] w;
    fe_t          a_r;

    tbl[0] = '{fe_t'(2), (fe_t'(1) << 254) - fe_t'(9), LAT_MAX};
    tbl[1] = '{P - fe_t'(1), P - fe_t'(1), LAT_MAX};
    tbl[2] = '{fe_t'(0), fe_t'(0), 2};
    w = (258'(P) * 258'd2 + 258'd1) / 258'd3;
    tbl[3] = '{fe_t'(3), w[254:0], LAT_MAX};
    tbl[4] = '{fe_t'(1), fe_t'(1), LAT_MAX};
    w = (258'(P) * 258'd3 + 258'd1) / 258'd4;
    tbl[5] = '{fe_t'(4), w[254:0], LAT_MAX};

    rst   = 1'b1;
    bus.a = fe_t'(1);
    #1;
    check_fe("reset_res", bus.res, '0);
    check_bit("reset_valid", bus.valid, 1'b0);
    check_bit("reset_idle", bus.dbg_state == IDLE, 1'b1);

    // a = 1 straight out of reset
    exp_q.push_back(fe_t'(1));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    finish_vec(fe_t'(1), LAT_MAX);

    for (int i = 0; i < 6; i++) begin
      run_vec(tbl[i].a, tbl[i].exp_res, tbl[i].max_lat);
    end

    // abort mid-RUN: res must hold the old result until the restart finishes
    set_a(fe_t'(121666));
    repeat (50) @(negedge clk);
    check_fe("abort_hold_res", bus.res, last_exp);
    check_bit("abort_run_valid", bus.valid, 1'b0);
    exp_q.push_back(modinv(fe_t'(9)));
    set_a(fe_t'(9));
    check_bit("abort_valid_now", bus.valid, 1'b0);
    finish_vec(fe_t'(9), LAT_MAX + 1);

    // leaving DONE: valid must drop in the cycle a changes
    exp_q.push_back(modinv(fe_t'(121666)));
    set_a(fe_t'(121666));
    check_bit("drop_valid_now", bus.valid, 1'b0);
    finish_vec(fe_t'(121666), LAT_MAX);

    // reset mid-RUN clears outputs at once, then the same a restarts
    a_r = rand_fe();
    exp_q.push_back(modinv(a_r));
    set_a(a_r);
    repeat (20) @(negedge clk);
    rst = 1'b1;
    #1;
    check_fe("midrst_res", bus.res, '0);
    check_bit("midrst_valid", bus.valid, 1'b0);
    check_bit("midrst_idle", bus.dbg_state == IDLE, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    finish_vec(a_r, LAT_MAX);

`ifdef FFI_REDUCE_IN_EN
    run_vec(P + fe_t'(1), fe_t'(1), LAT_MAX);
    run_vec(P, fe_t'(0), 2);
`endif

    for (int i = 0; i < N_RAND; i++) begin
      a_r = rand_fe();
      run_vec(a_r, modinv(a_r), LAT_MAX);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
